// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one fixed-latency pipelined multiplier among NREQ
// requesters. Round-robin grant, requester tags travel in a shadow pipeline
// alongside the multiplier, and products are collected in a result FIFO.
// A credit counter stops issue so the non-stallable multiplier can never
// overrun the FIFO.
//
// Optional build macro: MULT_SHARE_OPHOLD_EN
//   defined   -> mul_x/mul_y hold the last issued operands in idle cycles
//   undefined -> mul_x/mul_y return to 0 in every cycle not following an accept
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_x/req_y            packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_x/mul_y            registered operands to the multiplier
//   mul_p                  multiplier product, LAT cycles after mul_x/mul_y
//   rsp_valid/rsp_ready    result FIFO head handshake
//   rsp_id/rsp_product     head requester index and product (0 when empty)
//   busy                   credit count != 0
module mult_share_arbiter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LAT        = 3,
  parameter int unsigned FIFO_DEPTH = 6,
  localparam int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  output logic [WIDTH-1:0]        mul_x,
  output logic [WIDTH-1:0]        mul_y,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = IDW + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PW-1:0]  prod;
  } rsp_entry_t;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [SW-1:0]  scan;
  logic           issue_ok;
  logic           accept;
  logic           pop;
  logic           push;
  rsp_entry_t     push_data;

  logic [CW-1:0]  credit_q;
  logic [CW-1:0]  credit_nxt;

  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [LAT+1];

  rsp_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_nxt;
  logic [CW-1:0]  occ;
  logic [CW-1:0]  occ_nxt;
  rsp_entry_t     head_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Round-robin search; scanning offsets high to low leaves the nearest
  // valid requester at or after the pointer as the winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + SW'(i);
      if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
      if (req_valid[scan[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  // Issue only while a FIFO slot is guaranteed; no same-cycle pop bypass.
  assign issue_ok = !RST && (credit_q < CW'(FIFO_DEPTH));
  assign accept   = issue_ok && gnt_any;
  assign pop      = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // Operand registers feeding the multiplier.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_x <= '0;
      mul_y <= '0;
    end else if (accept) begin
      mul_x <= req_x[gnt_idx*WIDTH +: WIDTH];
      mul_y <= req_y[gnt_idx*WIDTH +: WIDTH];
    end
`ifndef MULT_SHARE_OPHOLD_EN
    else begin
      mul_x <= '0;
      mul_y <= '0;
    end
`endif
  end

  // Credit counter: one credit per op in flight or buffered.
  always_comb begin
    credit_nxt = credit_q;
    case ({accept, pop})
      2'b10:   credit_nxt = credit_q + CW'(1);
      2'b01:   credit_nxt = credit_q - CW'(1);
      default: credit_nxt = credit_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      credit_q <= '0;
      busy     <= 1'b0;
    end else begin
      credit_q <= credit_nxt;
      busy     <= (credit_nxt != '0);
    end
  end

  // Tag shadow pipeline; stage LAT lines up with the product on mul_p.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_v <= '0;
      for (int i = 0; i <= int'(LAT); i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[LAT-1:0], accept};
      tag_id[0] <= gnt_idx;
      for (int i = 1; i <= int'(LAT); i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign push      = tag_v[LAT] && !RST;
  assign push_data = '{id: tag_id[LAT], prod: mul_p};

  // FIFO bookkeeping and next head; a push into an otherwise empty FIFO
  // becomes the head directly.
  always_comb begin
    rd_nxt  = pop ? ptr_inc(rd_ptr) : rd_ptr;
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + CW'(1);
      2'b01:   occ_nxt = occ - CW'(1);
      default: occ_nxt = occ;
    endcase
    if (occ_nxt == '0)                   head_nxt = '0;
    else if (push && occ_nxt == CW'(1))  head_nxt = push_data;
    else                                 head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr      <= rd_nxt;
      occ         <= occ_nxt;
      rsp_valid   <= (occ_nxt != '0);
      rsp_id      <= head_nxt.id;
      rsp_product <= head_nxt.prod;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a per-cycle vector table for single
// op, round-robin and drain, then hand sequences for pointer skip, full /
// backpressure, reset mid-flight and operand hold.
module tb_mult_share_arbiter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREQ  = 4;

`ifdef MULT_SHARE_OPHOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [15:0] mul_x;
  logic [15:0] mul_y;
  logic [31:0] mul_p = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;
  logic        busy;

  logic [15:0] xv [4];
  logic [15:0] yv [4];
  assign req_x = {xv[3], xv[2], xv[1], xv[0]};
  assign req_y = {yv[3], yv[2], yv[1], yv[0]};

  mult_share_arbiter #(.WIDTH(16), .NREQ(4), .LAT(3), .FIFO_DEPTH(6)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Three-cycle multiplier stand-in.
  logic [31:0] p1 = '0;
  logic [31:0] p2 = '0;
  always @(posedge CLK) begin
    p1    <= 32'(mul_x) * 32'(mul_y);
    p2    <= p1;
    mul_p <= p2;
  end

  // Products of the default operand set, by requester.
  logic [31:0] prod_c [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        rrdy;
    logic [3:0]  e_rdy;
    logic [15:0] e_mx;
    logic        e_fresh;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [31:0] e_p;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [3:0] vld, input logic rrdy,
                     input logic [3:0] e_rdy, input logic [15:0] e_mx,
                     input logic e_fresh, input logic e_rv, input logic [1:0] e_id,
                     input logic [31:0] e_p, input logic e_busy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rrdy = rrdy; v.e_rdy = e_rdy; v.e_mx = e_mx;
    v.e_fresh = e_fresh; v.e_rv = e_rv; v.e_id = e_id; v.e_p = e_p; v.e_busy = e_busy;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc_chk(input string name, input logic [3:0] e_rdy, input logic e_rv,
                         input logic [1:0] e_id, input logic [31:0] e_p, input logic e_busy);
    chk({name, " req_ready"}, 32'(req_ready), 32'(e_rdy));
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'(e_rv));
    chk({name, " rsp_id"}, 32'(rsp_id), 32'(e_id));
    chk({name, " rsp_product"}, rsp_product, e_p);
    chk({name, " busy"}, 32'(busy), 32'(e_busy));
  endtask

  // Apply inputs just after a posedge, then move to the sampling point.
  task automatic drive(input logic rst, input logic [3:0] v, input logic rr);
    RST       = rst;
    req_valid = v;
    rsp_ready = rr;
    @(negedge CLK);
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] pv [4];
    logic [3:0] pe [4];
    logic       dv [6];
    logic [1:0] di [6];
    logic [1:0] bid [7];

    RST = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    xv[0] = 16'hFFFF; yv[0] = 16'hFFFF;
    xv[1] = 16'h0003; yv[1] = 16'h0005;
    xv[2] = 16'h1234; yv[2] = 16'h0010;
    xv[3] = 16'h0100; yv[3] = 16'h0200;
    prod_c[0] = 32'hFFFE0001; prod_c[1] = 32'h0000000F;
    prod_c[2] = 32'h00012340; prod_c[3] = 32'h00020000;

    //  rst vld    rrdy e_rdy    mul_x      fr rv id  product        busy
    add(1, 4'hF,  0,   4'b0000, 16'h0000, 0, 0, 0, 32'h0,          0);
    add(0, 4'h0,  0,   4'b0000, 16'h0000, 0, 0, 0, 32'h0,          0);
    add(0, 4'h4,  0,   4'b0100, 16'h0000, 0, 0, 0, 32'h0,          0);
    add(0, 4'h0,  0,   4'b0000, 16'h1234, 1, 0, 0, 32'h0,          1);
    add(0, 4'h0,  0,   4'b0000, 16'h1234, 0, 0, 0, 32'h0,          1);
    add(0, 4'h0,  0,   4'b0000, 16'h1234, 0, 0, 0, 32'h0,          1);
    add(0, 4'h0,  0,   4'b0000, 16'h1234, 0, 0, 0, 32'h0,          1);
    add(0, 4'h0,  0,   4'b0000, 16'h1234, 0, 1, 2, 32'h00012340,   1);
    add(0, 4'h0,  1,   4'b0000, 16'h1234, 0, 1, 2, 32'h00012340,   1);
    add(0, 4'h0,  1,   4'b0000, 16'h1234, 0, 0, 0, 32'h0,          0);
    add(0, 4'hF,  1,   4'b1000, 16'h1234, 0, 0, 0, 32'h0,          0);
    add(0, 4'hF,  1,   4'b0001, 16'h0100, 1, 0, 0, 32'h0,          1);
    add(0, 4'hF,  1,   4'b0010, 16'hFFFF, 1, 0, 0, 32'h0,          1);
    add(0, 4'hF,  1,   4'b0100, 16'h0003, 1, 0, 0, 32'h0,          1);
    add(0, 4'hF,  1,   4'b1000, 16'h1234, 1, 0, 0, 32'h0,          1);
    add(0, 4'hF,  1,   4'b0001, 16'h0100, 1, 1, 3, 32'h00020000,   1);
    add(0, 4'h0,  1,   4'b0000, 16'hFFFF, 1, 1, 0, 32'hFFFE0001,   1);
    add(0, 4'h0,  1,   4'b0000, 16'hFFFF, 0, 1, 1, 32'h0000000F,   1);
    add(0, 4'h0,  1,   4'b0000, 16'hFFFF, 0, 1, 2, 32'h00012340,   1);
    add(0, 4'h0,  1,   4'b0000, 16'hFFFF, 0, 1, 3, 32'h00020000,   1);
    add(0, 4'h0,  1,   4'b0000, 16'hFFFF, 0, 1, 0, 32'hFFFE0001,   1);
    add(0, 4'h0,  1,   4'b0000, 16'hFFFF, 0, 0, 0, 32'h0,          0);

    repeat (2) @(posedge CLK);
    #1;

    // Single op, round-robin with no bubbles, in-order drain.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].vld, vq[i].rrdy);
      cyc_chk($sformatf("row%0d", i), vq[i].e_rdy, vq[i].e_rv, vq[i].e_id,
              vq[i].e_p, vq[i].e_busy);
      chk($sformatf("row%0d mul_x", i), 32'(mul_x),
          32'((vq[i].e_fresh || HOLD) ? vq[i].e_mx : 16'h0000));
      next_cyc();
    end

    // Pointer wrap/skip: only 1 and 3 valid once the pointer sits at 2.
    pv[0] = 4'b0010; pv[1] = 4'b1010; pv[2] = 4'b1010; pv[3] = 4'b1010;
    pe[0] = 4'b0010; pe[1] = 4'b1000; pe[2] = 4'b0010; pe[3] = 4'b1000;
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, pv[p], 1'b1);
      chk($sformatf("skip%0d req_ready", p), 32'(req_ready), 32'(pe[p]));
      next_cyc();
    end
    dv[0] = 0; dv[1] = 1; dv[2] = 1; dv[3] = 1; dv[4] = 1; dv[5] = 0;
    di[0] = 0; di[1] = 1; di[2] = 3; di[3] = 1; di[4] = 3; di[5] = 0;
    for (int p = 0; p < 6; p++) begin
      drive(1'b0, 4'h0, 1'b1);
      cyc_chk($sformatf("skipdrain%0d", p), 4'b0000, dv[p], di[p],
              dv[p] ? prod_c[di[p]] : 32'h0, (p < 5) ? 1'b1 : 1'b0);
      next_cyc();
    end

    // Full FIFO under backpressure, then drain with re-issue.
    bid[0] = 0; bid[1] = 1; bid[2] = 2; bid[3] = 3; bid[4] = 0; bid[5] = 1; bid[6] = 2;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] er;
      logic       erv;
      logic [1:0] eid;
      er  = 4'b0000;
      if (k < 6)   er = 4'(1 << (k % 4));
      if (k == 13) er = 4'b0100;
      erv = (k >= 5 && k <= 18);
      eid = (k >= 12 && k <= 18) ? bid[k-12] : 2'd0;
      drive(1'b0, (k <= 13) ? 4'hF : 4'h0, (k >= 12) ? 1'b1 : 1'b0);
      cyc_chk($sformatf("full%0d", k), er, erv, eid, erv ? prod_c[eid] : 32'h0,
              (k == 0 || k == 19) ? 1'b0 : 1'b1);
      next_cyc();
    end

    // Reset one cycle before the first push of three in-flight ops.
    pe[0] = 4'b1000; pe[1] = 4'b0001; pe[2] = 4'b0010;
    for (int a = 0; a < 3; a++) begin
      drive(1'b0, 4'hF, 1'b1);
      cyc_chk($sformatf("rstmid%0d", a), pe[a], 1'b0, 2'd0, 32'h0, (a == 0) ? 1'b0 : 1'b1);
      next_cyc();
    end
    drive(1'b1, 4'h0, 1'b1);
    chk("rstmid reset req_ready", 32'(req_ready), 32'h0);
    next_cyc();
    for (int a = 4; a < 12; a++) begin
      drive(1'b0, 4'h0, 1'b1);
      cyc_chk($sformatf("postrst%0d", a), 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0);
      chk($sformatf("postrst%0d mul_x", a), 32'(mul_x), 32'h0);
      next_cyc();
    end

    // Pointer back at 0 after reset, then operand hold after x=0xABCD.
    drive(1'b0, 4'hF, 1'b1);
    cyc_chk("after_rst b0", 4'b0001, 1'b0, 2'd0, 32'h0, 1'b0);
    next_cyc();
    xv[1] = 16'hABCD; yv[1] = 16'h0002;
    drive(1'b0, 4'b0010, 1'b1);
    cyc_chk("after_rst b1", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b1);
    chk("after_rst b1 mul_x", 32'(mul_x), 32'h0000FFFF);
    next_cyc();
    drive(1'b0, 4'h0, 1'b1);
    chk("hold b2 mul_x", 32'(mul_x), 32'h0000ABCD);
    chk("hold b2 mul_y", 32'(mul_y), 32'h00000002);
    next_cyc();
    drive(1'b0, 4'h0, 1'b1);
    chk("hold b3 mul_x", 32'(mul_x), HOLD ? 32'h0000ABCD : 32'h0);
    next_cyc();
    drive(1'b0, 4'h0, 1'b1);
    cyc_chk("hold b4", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    next_cyc();
    drive(1'b0, 4'h0, 1'b1);
    cyc_chk("hold b5", 4'b0000, 1'b1, 2'd0, 32'hFFFE0001, 1'b1);
    next_cyc();
    drive(1'b0, 4'h0, 1'b1);
    cyc_chk("hold b6", 4'b0000, 1'b1, 2'd1, 32'h0001579A, 1'b1);
    next_cyc();
    drive(1'b0, 4'h0, 1'b1);
    cyc_chk("hold b7", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0);
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
